// File: rtl/pulp_io_pkg.sv
// Shared types for the pulp_io L2 port merge: source IDs, bus structs and
// the arbiter state record.
package pulp_io_pkg;

  localparam int unsigned L2_ADDR_WIDTH = 32;
  localparam int unsigned L2_DW         = 32;

  typedef enum logic {
    SRC_RO = 1'b0,
    SRC_WO = 1'b1
  } l2_src_e;

  typedef struct packed {
    logic                     req;
    logic                     wen;
    logic [L2_ADDR_WIDTH-1:0] addr;
    logic [L2_DW/8-1:0]       be;
    logic [L2_DW-1:0]         wdata;
  } l2_req_t;

  typedef struct packed {
    logic             gnt;
    logic             rvalid;
    logic [L2_DW-1:0] rdata;
  } l2_rsp_t;

  // Arbiter state, kept as one record so it can be probed as a unit.
  typedef struct packed {
    l2_src_e rr;
    logic    lock;
    l2_src_e lock_src;
  } arb_state_t;

  function automatic l2_src_e other_src(input l2_src_e s);
    return (s == SRC_RO) ? SRC_WO : SRC_RO;
  endfunction

endpackage

// File: rtl/pulp_io_l2_arbiter_if.sv
// TCDM-style L2 port bundle.
// Handshake: a transfer happens in the cycle where req and gnt are both high;
// each handshake is answered by exactly one rvalid, at least one cycle later,
// in issue order. A requester keeps req and its fields stable until granted.
interface pulp_io_l2_arbiter_if #(
  parameter int unsigned DW = 32
) ();

  logic            req;
  logic            wen;
  logic [31:0]     addr;
  logic [DW/8-1:0] be;
  logic [DW-1:0]   wdata;
  logic            gnt;
  logic            rvalid;
  logic [DW-1:0]   rdata;

  modport master (
    output req, wen, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, wen, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/pulp_io_l2_arbiter_core.sv
// Round-robin arbiter with request locking between the uDMA ro and wo ports,
// plus in-order response routing through the ID FIFO.
module pulp_io_l2_arbiter_core
  import pulp_io_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pulp_io_l2_arbiter_if.slave  ro_s,
  pulp_io_l2_arbiter_if.slave  wo_s,
  pulp_io_l2_arbiter_if.master l2_m
);

  arb_state_t state_q, state_d;
  l2_src_e    sel;
  logic       sel_req;
  logic       issue;
  logic       handshake;
  logic       fifo_full, fifo_empty;
  l2_src_e    fifo_head;
  logic       rsp_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '{rr: SRC_RO, lock: 1'b0, lock_src: SRC_RO};
    end else begin
      state_q <= state_d;
    end
  end

  // A request presented without a grant is pinned until it is accepted.
  always_comb begin
    state_d = state_q;
    if (handshake) begin
      state_d.rr   = other_src(sel);
      state_d.lock = 1'b0;
    end else if (issue) begin
      state_d.lock     = 1'b1;
      state_d.lock_src = sel;
    end
  end

  always_comb begin
    sel = SRC_RO;
    if (state_q.lock)               sel = state_q.lock_src;
    else if (ro_s.req && wo_s.req)  sel = state_q.rr;
    else if (wo_s.req)              sel = SRC_WO;
  end

  assign sel_req   = (sel == SRC_WO) ? wo_s.req : ro_s.req;
  // Gated by reset so the L2 port is quiet the instant reset asserts.
  assign issue     = sel_req & ~fifo_full & rst_ni;
  assign handshake = issue & l2_m.gnt;

  assign l2_m.req   = issue;
  assign l2_m.wen   = (sel == SRC_WO) ? wo_s.wen   : ro_s.wen;
  assign l2_m.addr  = (sel == SRC_WO) ? wo_s.addr  : ro_s.addr;
  assign l2_m.be    = (sel == SRC_WO) ? wo_s.be    : ro_s.be;
  assign l2_m.wdata = (sel == SRC_WO) ? wo_s.wdata : ro_s.wdata;

  assign ro_s.gnt = handshake & (sel == SRC_RO);
  assign wo_s.gnt = handshake & (sel == SRC_WO);

  assign rsp_ok      = l2_m.rvalid & ~fifo_empty;
  assign ro_s.rvalid = rsp_ok & (fifo_head == SRC_RO);
  assign wo_s.rvalid = rsp_ok & (fifo_head == SRC_WO);
  assign ro_s.rdata  = l2_m.rdata;
  assign wo_s.rdata  = l2_m.rdata;

  pulp_io_l2_id_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) i_id_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (handshake),
    .push_src_i (sel),
    .pop_i      (l2_m.rvalid),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (fifo_head)
  );

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(l2_m.rvalid && fifo_empty))
        else $error("l2 rvalid with no outstanding transaction");
      assert (!(state_q.lock && !sel_req))
        else $error("locked source dropped its request before grant");
    end
  end
`endif

endmodule

// File: rtl/pulp_io_l2_id_fifo.sv
// Outstanding-transaction ID FIFO: remembers which source owns each
// granted-but-unanswered L2 transaction, oldest at the head.
module pulp_io_l2_id_fifo
  import pulp_io_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  l2_src_e push_src_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output l2_src_e head_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  l2_src_e     mem_q [DEPTH];
  logic        do_push, do_pop;

  // Extra pointer MSB separates the full and empty cases at equal indices.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= SRC_RO;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= push_src_i;
    end
  end

endmodule

// File: rtl/pulp_io_l2_arbiter.sv
// Merges the uDMA ro and wo L2 master ports onto one L2 master port.
module pulp_io_l2_arbiter #(
  parameter int unsigned L2_DATA_WIDTH   = 32,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                       sys_clk_i,
  input  logic                       sys_rst_ni,

  input  logic                       ro_req_i,
  input  logic                       ro_wen_i,
  input  logic [31:0]                ro_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] ro_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   ro_wdata_i,
  output logic                       ro_gnt_o,
  output logic                       ro_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   ro_rdata_o,

  input  logic                       wo_req_i,
  input  logic                       wo_wen_i,
  input  logic [31:0]                wo_addr_i,
  input  logic [L2_DATA_WIDTH/8-1:0] wo_be_i,
  input  logic [L2_DATA_WIDTH-1:0]   wo_wdata_i,
  output logic                       wo_gnt_o,
  output logic                       wo_rvalid_o,
  output logic [L2_DATA_WIDTH-1:0]   wo_rdata_o,

  output logic                       l2_req_o,
  output logic                       l2_wen_o,
  output logic [31:0]                l2_addr_o,
  output logic [L2_DATA_WIDTH/8-1:0] l2_be_o,
  output logic [L2_DATA_WIDTH-1:0]   l2_wdata_o,
  input  logic                       l2_gnt_i,
  input  logic                       l2_rvalid_i,
  input  logic [L2_DATA_WIDTH-1:0]   l2_rdata_i
);

  pulp_io_l2_arbiter_if #(.DW(L2_DATA_WIDTH)) ro_bus ();
  pulp_io_l2_arbiter_if #(.DW(L2_DATA_WIDTH)) wo_bus ();
  pulp_io_l2_arbiter_if #(.DW(L2_DATA_WIDTH)) l2_bus ();

  assign ro_bus.req   = ro_req_i;
  assign ro_bus.wen   = ro_wen_i;
  assign ro_bus.addr  = ro_addr_i;
  assign ro_bus.be    = ro_be_i;
  assign ro_bus.wdata = ro_wdata_i;
  assign ro_gnt_o     = ro_bus.gnt;
  assign ro_rvalid_o  = ro_bus.rvalid;
  assign ro_rdata_o   = ro_bus.rdata;

  assign wo_bus.req   = wo_req_i;
  assign wo_bus.wen   = wo_wen_i;
  assign wo_bus.addr  = wo_addr_i;
  assign wo_bus.be    = wo_be_i;
  assign wo_bus.wdata = wo_wdata_i;
  assign wo_gnt_o     = wo_bus.gnt;
  assign wo_rvalid_o  = wo_bus.rvalid;
  assign wo_rdata_o   = wo_bus.rdata;

  assign l2_req_o      = l2_bus.req;
  assign l2_wen_o      = l2_bus.wen;
  assign l2_addr_o     = l2_bus.addr;
  assign l2_be_o       = l2_bus.be;
  assign l2_wdata_o    = l2_bus.wdata;
  assign l2_bus.gnt    = l2_gnt_i;
  assign l2_bus.rvalid = l2_rvalid_i;
  assign l2_bus.rdata  = l2_rdata_i;

  pulp_io_l2_arbiter_core #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) i_core (
    .clk_i  (sys_clk_i),
    .rst_ni (sys_rst_ni),
    .ro_s   (ro_bus),
    .wo_s   (wo_bus),
    .l2_m   (l2_bus)
  );

endmodule

// File: tb/tb_pulp_io_l2_arbiter.sv
// Bench for pulp_io_l2_arbiter: directed scenarios and random mixed traffic
// checked cycle by cycle against a queue-based reference model.
module tb_pulp_io_l2_arbiter;
  import pulp_io_pkg::*;

  localparam int unsigned DW     = 32;
  localparam int unsigned MAXO   = 4;
  localparam logic [31:0] RD_KEY = 32'hC2AD_BEEF;  // 0x1C000000 reads back 0xDEADBEEF

  typedef struct {
    logic [31:0] data;
    int unsigned ready;
  } pend_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pulp_io_l2_arbiter_if #(.DW(DW)) ro_if ();
  pulp_io_l2_arbiter_if #(.DW(DW)) wo_if ();
  pulp_io_l2_arbiter_if #(.DW(DW)) l2_if ();

  pulp_io_l2_arbiter #(.L2_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)) dut (
    .sys_clk_i   (clk),
    .sys_rst_ni  (rst_n),
    .ro_req_i    (ro_if.req),
    .ro_wen_i    (ro_if.wen),
    .ro_addr_i   (ro_if.addr),
    .ro_be_i     (ro_if.be),
    .ro_wdata_i  (ro_if.wdata),
    .ro_gnt_o    (ro_if.gnt),
    .ro_rvalid_o (ro_if.rvalid),
    .ro_rdata_o  (ro_if.rdata),
    .wo_req_i    (wo_if.req),
    .wo_wen_i    (wo_if.wen),
    .wo_addr_i   (wo_if.addr),
    .wo_be_i     (wo_if.be),
    .wo_wdata_i  (wo_if.wdata),
    .wo_gnt_o    (wo_if.gnt),
    .wo_rvalid_o (wo_if.rvalid),
    .wo_rdata_o  (wo_if.rdata),
    .l2_req_o    (l2_if.req),
    .l2_wen_o    (l2_if.wen),
    .l2_addr_o   (l2_if.addr),
    .l2_be_o     (l2_if.be),
    .l2_wdata_o  (l2_if.wdata),
    .l2_gnt_i    (l2_if.gnt),
    .l2_rvalid_i (l2_if.rvalid),
    .l2_rdata_i  (l2_if.rdata)
  );

  // ---------------- reference model / scoreboard ----------------
  int          test_cnt = 0;
  int          fail_cnt = 0;
  int unsigned cyc = 0;

  l2_src_e     m_q[$];          // owners of outstanding transactions, oldest first
  l2_src_e     m_prio;          // source winning a tie
  bit          m_held;          // an ungranted request is pinned
  l2_src_e     m_held_src;
  logic [DW-1:0] ro_exp_q[$];
  logic [DW-1:0] wo_exp_q[$];

  pend_t       pend_q[$];       // L2 responder: answers not yet returned
  bit          rsp_hold = 1'b0;
  int unsigned rsp_lat  = 1;

  bit          exp_req, exp_hs, exp_rv, rv_now, dut_hs, ro_g, wo_g;
  l2_src_e     exp_sel;
  logic [31:0] exp_addr, dut_addr;
  int          ro_hs_cnt, wo_hs_cnt, ro_rv_cnt, wo_rv_cnt;

  function automatic logic [31:0] rd_of(input logic [31:0] a);
    return a ^ RD_KEY;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge with this cycle's inputs already set.
  task automatic settle();
    l2_if.rvalid = 1'b0;
    l2_if.rdata  = '0;
    rv_now       = 1'b0;
    if (rst_n && !rsp_hold && pend_q.size() > 0 && pend_q[0].ready <= cyc) begin
      l2_if.rvalid = 1'b1;
      l2_if.rdata  = pend_q[0].data;
      rv_now       = 1'b1;
    end
    #1;
    if (m_held)                        exp_sel = m_held_src;
    else if (ro_if.req && wo_if.req)   exp_sel = m_prio;
    else if (wo_if.req)                exp_sel = SRC_WO;
    else                               exp_sel = SRC_RO;
    exp_addr = (exp_sel == SRC_WO) ? wo_if.addr : ro_if.addr;
    exp_req  = rst_n && ((exp_sel == SRC_WO) ? wo_if.req : ro_if.req) && (m_q.size() < MAXO);
    exp_hs   = exp_req && l2_if.gnt;
    exp_rv   = l2_if.rvalid && (m_q.size() > 0);

    chk("l2_req",    l2_if.req,   exp_req);
    chk("l2_addr",   l2_if.addr,  exp_addr);
    chk("l2_wen",    l2_if.wen,   (exp_sel == SRC_WO) ? wo_if.wen   : ro_if.wen);
    chk("l2_be",     l2_if.be,    (exp_sel == SRC_WO) ? wo_if.be    : ro_if.be);
    chk("l2_wdata",  l2_if.wdata, (exp_sel == SRC_WO) ? wo_if.wdata : ro_if.wdata);
    chk("ro_gnt",    ro_if.gnt,   exp_hs && exp_sel == SRC_RO);
    chk("wo_gnt",    wo_if.gnt,   exp_hs && exp_sel == SRC_WO);
    chk("ro_rvalid", ro_if.rvalid, exp_rv && m_q[0] == SRC_RO);
    chk("wo_rvalid", wo_if.rvalid, exp_rv && m_q[0] == SRC_WO);
    if (exp_rv && m_q[0] == SRC_RO && ro_exp_q.size() > 0) begin
      chk("ro_rdata", ro_if.rdata, ro_exp_q[0]);
      void'(ro_exp_q.pop_front());
    end
    if (exp_rv && m_q[0] == SRC_WO && wo_exp_q.size() > 0) begin
      chk("wo_rdata", wo_if.rdata, wo_exp_q[0]);
      void'(wo_exp_q.pop_front());
    end

    ro_g     = ro_if.gnt;
    wo_g     = wo_if.gnt;
    dut_hs   = l2_if.req && l2_if.gnt;
    dut_addr = l2_if.addr;
    if (ro_if.gnt)    ro_hs_cnt++;
    if (wo_if.gnt)    wo_hs_cnt++;
    if (ro_if.rvalid) ro_rv_cnt++;
    if (wo_if.rvalid) wo_rv_cnt++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (exp_rv) void'(m_q.pop_front());
      if (exp_hs) begin
        m_q.push_back(exp_sel);
        m_prio = (exp_sel == SRC_RO) ? SRC_WO : SRC_RO;
        m_held = 1'b0;
        if (exp_sel == SRC_RO) ro_exp_q.push_back(rd_of(exp_addr));
        else                   wo_exp_q.push_back(rd_of(exp_addr));
      end else if (exp_req) begin
        m_held     = 1'b1;
        m_held_src = exp_sel;
      end
      if (rv_now) void'(pend_q.pop_front());
      if (dut_hs) pend_q.push_back('{data: rd_of(dut_addr), ready: cyc + rsp_lat});
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_q.delete(); pend_q.delete(); ro_exp_q.delete(); wo_exp_q.delete();
    m_prio = SRC_RO; m_held = 1'b0; m_held_src = SRC_RO;
    ro_hs_cnt = 0; wo_hs_cnt = 0; ro_rv_cnt = 0; wo_rv_cnt = 0;
    #1;
    chk("rst_l2_req",    l2_if.req,    1'b0);
    chk("rst_ro_gnt",    ro_if.gnt,    1'b0);
    chk("rst_wo_gnt",    wo_if.gnt,    1'b0);
    chk("rst_ro_rvalid", ro_if.rvalid, 1'b0);
    chk("rst_wo_rvalid", wo_if.rvalid, 1'b0);
    chk("rst_l2_wen",    l2_if.wen,    ro_if.wen);
    l2_if.rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    l2_if.gnt = 1'b1;
    rsp_hold  = 1'b0;
    while ((ro_if.req || wo_if.req || pend_q.size() > 0 || m_q.size() > 0) && guard < 100) begin
      settle();
      tick();
      if (ro_g) ro_if.req = 1'b0;
      if (wo_g) wo_if.req = 1'b0;
      guard++;
    end
    chk({tag, "_drained"},  m_q.size(), 0);
    chk({tag, "_ro_count"}, ro_rv_cnt, ro_hs_cnt);
    chk({tag, "_wo_count"}, wo_rv_cnt, wo_hs_cnt);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n_hs;
    rst_n = 1'b1;
    ro_if.req = 1'b1; ro_if.wen = 1'b1; ro_if.addr = '0; ro_if.be = '1; ro_if.wdata = '0;
    wo_if.req = 1'b1; wo_if.wen = 1'b0; wo_if.addr = '0; wo_if.be = '1; wo_if.wdata = '0;
    l2_if.gnt = 1'b1; l2_if.rvalid = 1'b0; l2_if.rdata = '0;
    #1;
    do_reset();
    ro_if.req = 1'b0; wo_if.req = 1'b0;

    // single ro read, answered two cycles later
    rsp_lat = 2;
    ro_if.req = 1'b1; ro_if.wen = 1'b1; ro_if.addr = 32'h1C00_0000;
    settle(); chk("t1_ro_gnt", ro_if.gnt, 1'b1); tick();
    ro_if.req = 1'b0;
    settle(); chk("t1_early_rvalid", ro_if.rvalid, 1'b0); tick();
    settle();
    chk("t1_ro_rvalid", ro_if.rvalid, 1'b1);
    chk("t1_ro_rdata",  ro_if.rdata,  32'hDEAD_BEEF);
    chk("t1_wo_rvalid", wo_if.rvalid, 1'b0);
    tick();
    rsp_lat = 1;
    drain("t1");

    // continuous requests from both sources alternate from reset
    do_reset();
    ro_if.req = 1'b1; ro_if.addr = 32'h1C00_0100; ro_if.wen = 1'b1;
    wo_if.req = 1'b1; wo_if.addr = 32'h1C00_0200; wo_if.wen = 1'b0; wo_if.wdata = 32'h1234_5678;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t2_alt_ro", ro_if.gnt, (k % 2) == 0);
      chk("t2_alt_wo", wo_if.gnt, (k % 2) == 1);
      tick();
      if (ro_g) ro_if.addr = ro_if.addr + 32'd4;
      if (wo_g) wo_if.addr = wo_if.addr + 32'd4;
    end
    ro_if.req = 1'b0; wo_if.req = 1'b0;
    drain("t2");

    // stalled wo write keeps the L2 port while ro asserts behind it
    wo_if.req = 1'b1; wo_if.wen = 1'b0; wo_if.addr = 32'h1C00_0010;
    wo_if.wdata = 32'hA5A5_A5A5; wo_if.be = 4'hF;
    ro_if.req = 1'b0; ro_if.addr = 32'h1C00_0300; ro_if.wen = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) ro_if.req = 1'b1;
      l2_if.gnt = (k >= 3);
      settle();
      if (k <= 3) begin
        chk("t3_addr_held",  l2_if.addr,  32'h1C00_0010);
        chk("t3_wdata_held", l2_if.wdata, 32'hA5A5_A5A5);
      end
      chk("t3_wo_gnt", wo_if.gnt, k == 3);
      chk("t3_ro_gnt", ro_if.gnt, k == 4);
      tick();
      if (wo_g) wo_if.req = 1'b0;
      if (ro_g) ro_if.req = 1'b0;
    end
    drain("t3");

    // FIFO full blocks issue; a pop unblocks it one cycle later
    rsp_hold = 1'b1; l2_if.gnt = 1'b1;
    ro_if.req = 1'b1; ro_if.addr = 32'h1C00_0400;
    for (int k = 0; k < 4; k++) begin
      settle(); chk("t4_fill_gnt", ro_if.gnt, 1'b1); tick();
      ro_if.addr = ro_if.addr + 32'd4;
    end
    settle();
    chk("t4_full_req", l2_if.req, 1'b0);
    chk("t4_full_gnt", ro_if.gnt, 1'b0);
    tick();
    rsp_hold = 1'b0;
    settle();
    chk("t4_pop_rvalid",  ro_if.rvalid, 1'b1);
    chk("t4_no_bypass",   l2_if.req,    1'b0);
    tick();
    rsp_hold = 1'b1;
    settle();
    chk("t4_issue_req", l2_if.req, 1'b1);
    chk("t4_issue_gnt", ro_if.gnt, 1'b1);
    tick();
    ro_if.req = 1'b0;
    drain("t4");

    // random mixed traffic, responses with latency 1
    n_hs = 0;
    for (int c = 0; c < 3000 && n_hs < 200; c++) begin
      if (!ro_if.req && $urandom_range(0, 3) != 0) begin
        ro_if.req = 1'b1; ro_if.wen = 1'($urandom_range(0, 1));
        ro_if.addr = $urandom; ro_if.be = 4'($urandom); ro_if.wdata = $urandom;
      end
      if (!wo_if.req && $urandom_range(0, 3) != 0) begin
        wo_if.req = 1'b1; wo_if.wen = 1'($urandom_range(0, 1));
        wo_if.addr = $urandom; wo_if.be = 4'($urandom); wo_if.wdata = $urandom;
      end
      l2_if.gnt = ($urandom_range(0, 3) != 0);
      settle();
      tick();
      if (ro_g) begin ro_if.req = 1'b0; n_hs++; end
      if (wo_g) begin wo_if.req = 1'b0; n_hs++; end
    end
    chk("t5_budget", n_hs >= 200, 1'b1);
    drain("t5");

    // reset with outstanding transactions and an active lock
    rsp_hold = 1'b1; l2_if.gnt = 1'b1;
    ro_if.req = 1'b1; ro_if.addr = 32'h1C00_0500;
    for (int k = 0; k < 3; k++) begin
      settle(); tick();
      ro_if.addr = ro_if.addr + 32'd4;
    end
    ro_if.req = 1'b0; wo_if.req = 1'b1; wo_if.addr = 32'h1C00_0600; l2_if.gnt = 1'b0;
    settle(); chk("t6_lock_presented", l2_if.req, 1'b1); tick();
    chk("t6_outstanding", m_q.size(), 3);
    ro_if.req = 1'b1; l2_if.gnt = 1'b1; l2_if.rvalid = 1'b1; ro_if.wen = 1'b1;
    do_reset();
    rsp_hold = 1'b0;
    settle();
    chk("t6_first_ro", ro_if.gnt, 1'b1);
    chk("t6_first_wo", wo_if.gnt, 1'b0);
    tick();
    if (ro_g) ro_if.req = 1'b0;
    if (wo_g) wo_if.req = 1'b0;
    drain("t6");

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/pulp_io_l2_arbiter.md
Name: pulp_io_l2_arbiter

Overview:
- Merges the uDMA read-only (ro) and write-only (wo) L2 master ports onto a single L2 master port, for integrations that expose one L2 slave to the IO subsystem.
- Sits between udma_subsystem and the SoC L2 interconnect inside pulp_io.
- Provides round-robin arbitration with request locking, and in-order response routing through an outstanding-ID FIFO.

Parameters:
- L2_DATA_WIDTH, 32, data width of all three ports; byte-enable width is L2_DATA_WIDTH/8.
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions; power of two, at least 2.

Ports:
- sys_clk_i  in  1  udma core clock
- sys_rst_ni  in  1  asynchronous active-low reset
- ro_req_i, ro_wen_i  in  1, 1  ro request; wen high = read
- ro_addr_i  in  32  ro address
- ro_be_i  in  L2_DATA_WIDTH/8  ro byte enables
- ro_wdata_i  in  L2_DATA_WIDTH  ro write data
- ro_gnt_o, ro_rvalid_o  out  1, 1  ro grant, ro response valid
- ro_rdata_o  out  L2_DATA_WIDTH  ro read data
- wo_req_i, wo_wen_i, wo_addr_i, wo_be_i, wo_wdata_i, wo_gnt_o, wo_rvalid_o, wo_rdata_o  same widths and meaning as the ro_* group
- l2_req_o, l2_wen_o  out  1, 1  merged request, merged wen
- l2_addr_o  out  32  merged address
- l2_be_o  out  L2_DATA_WIDTH/8  merged byte enables
- l2_wdata_o  out  L2_DATA_WIDTH  merged write data
- l2_gnt_i, l2_rvalid_i  in  1, 1  L2 grant, L2 response valid
- l2_rdata_i  in  L2_DATA_WIDTH  L2 read data

Behaviour:
- Protocol, all ports: TCDM-style.
  - Handshake = req & gnt in the same cycle.
  - Exactly one rvalid per handshake, reads and writes alike, at least 1 cycle later, in order.
- Source IDs: SRC_RO = 0, SRC_WO = 1.
- State:
  - rr_q: 1 bit, source that has priority next; reset SRC_RO.
  - lock_q / lock_src_q: a request is pending at L2 without a grant; reset 0 / SRC_RO.
  - ID FIFO: depth MAX_OUTSTANDING, 1-bit entries; reset empty.
- Selection, combinational:
  - If lock_q, sel = lock_src_q.
  - Else if exactly one source requests, sel = that source.
  - Else if both request, sel = rr_q.
  - Else sel = SRC_RO (idle).
- Issue: l2_req_o = req of sel & ~fifo_full.
  - Full blocks issue even when a pop occurs in the same cycle; no bypass.
- Request path, zero latency: l2_wen/addr/be/wdata_o = fields of sel. When idle they carry the ro fields with l2_req_o = 0.
- Grant: gnt_o of sel = l2_gnt_i & l2_req_o; the other gnt_o = 0. A source gnt_o is never high while its req_i is low.
- On handshake:
  - push sel into the ID FIFO;
  - rr_q <= ~sel;
  - lock_q <= 0.
- On l2_req_o & ~l2_gnt_i: lock_q <= 1 and lock_src_q <= sel.
  - Keeps the presented request stable until granted, even if the other source asserts with higher rr priority.
- Response path, zero latency:
  - When l2_rvalid_i is high, pop the FIFO head and raise rvalid_o of the head source only.
  - rdata_i is broadcast to both rdata_o outputs.
- rvalid with an empty FIFO: dropped, no pop; a simulation-only assertion fires.
- Simultaneous push and pop (not full): both occur; occupancy is unchanged.
- A source deasserting req while locked is a protocol violation; flagged by assertion, behaviour undefined.
- Reset values: all gnt_o, rvalid_o and l2_req_o are 0; l2_wen_o = ro_wen_i.
- Reset mid-operation: FIFO, lock and rr are cleared asynchronously. Any in-flight responses are the integrator's responsibility; L2 shares sys_rst_ni.
- Throughput: one handshake per cycle while the FIFO is not full. Sustained alternation when both sources request continuously.

Decomposition:
- pulp_io_pkg gains:
  - l2_src_e enum (SRC_RO, SRC_WO);
  - l2_req_t struct (req, wen, addr, be, wdata);
  - l2_rsp_t struct (gnt, rvalid, rdata).
- Sub-module pulp_io_l2_id_fifo: 1-bit wide, MAX_OUTSTANDING deep, with push, pop, full, empty and head outputs. Pointer-based, async reset.

Test Plan:
- Single ro read at 0x1C00_0000, l2_gnt tied 1, rvalid 2 cycles later with rdata 0xDEADBEEF -> ro_gnt_o in the request cycle, ro_rvalid_o with 0xDEADBEEF, wo_rvalid_o stays 0.
- ro and wo requesting continuously, l2_gnt = 1 -> grants alternate RO, WO, RO, WO from reset; responses are routed to matching sources in order.
- wo writes 0xA5A5A5A5 to 0x1C00_0010 with l2_gnt held 0 for 3 cycles; ro asserts in cycle 1 -> l2 port fields stay wo throughout; wo granted in cycle 3; ro granted the next cycle.
- 4 ro reads granted with no rvalid (MAX_OUTSTANDING = 4) -> l2_req_o = 0 and ro_gnt_o = 0 on the 5th request. One rvalid -> 5th request issued the following cycle.
- Back-to-back mixed traffic with rvalid every cycle and latency 1, 200 random transactions -> per-source response count equals handshake count; data order matches a scoreboard.
- Assert sys_rst_ni low with 3 outstanding and lock active -> gnts, rvalids and l2_req_o go 0 immediately. After release, FIFO is empty and the first grant goes to ro.
